// File: rtl/bus_dest_regs.sv
// ============================================================================
// Module      : bus_dest_regs
// Description : Bus-destination register file (R0-R15, HI, LO, Z, PC, MDR,
//               OUTPORT, MAR) with write acknowledge and sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_dest_regs #(
  parameter int DEST_W = 5
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [31:0]       bus_data,
  input  logic [DEST_W-1:0] dest_sel,
  input  logic              dest_wr,
  input  logic              md_read,
  input  logic [31:0]       mem_data_in,
  input  logic              z_in,
  input  logic [63:0]       alu_result,
  input  logic              pc_inc,
  input  logic              clr_err,
  output logic [31:0]       BusMuxInR0,
  output logic [31:0]       BusMuxInR1,
  output logic [31:0]       BusMuxInR2,
  output logic [31:0]       BusMuxInR3,
  output logic [31:0]       BusMuxInR4,
  output logic [31:0]       BusMuxInR5,
  output logic [31:0]       BusMuxInR6,
  output logic [31:0]       BusMuxInR7,
  output logic [31:0]       BusMuxInR8,
  output logic [31:0]       BusMuxInR9,
  output logic [31:0]       BusMuxInR10,
  output logic [31:0]       BusMuxInR11,
  output logic [31:0]       BusMuxInR12,
  output logic [31:0]       BusMuxInR13,
  output logic [31:0]       BusMuxInR14,
  output logic [31:0]       BusMuxInR15,
  output logic [31:0]       Hi_Data_Out,
  output logic [31:0]       Lo_Data_Out,
  output logic [31:0]       ZHi_Data_Out,
  output logic [31:0]       ZLo_Data_Out,
  output logic [31:0]       PC_Data_Out,
  output logic [31:0]       MDR_Data_Out,
  output logic [31:0]       Out_Port_Data,
  output logic [31:0]       MAR_Data_Out,
  output logic              wr_ack,
  output logic              wr_err
);

  localparam logic [DEST_W-1:0] C_SEL_GPR_END = DEST_W'(16);
  localparam logic [DEST_W-1:0] C_SEL_HI      = DEST_W'(16);
  localparam logic [DEST_W-1:0] C_SEL_LO      = DEST_W'(17);
  localparam logic [DEST_W-1:0] C_SEL_PC      = DEST_W'(20);
  localparam logic [DEST_W-1:0] C_SEL_MDR     = DEST_W'(21);
  localparam logic [DEST_W-1:0] C_SEL_OUT     = DEST_W'(22);
  localparam logic [DEST_W-1:0] C_SEL_MAR     = DEST_W'(23);

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_zhi, r_zlo, r_pc, r_mdr, r_out, r_mar;
  logic        r_ack, r_err;

  logic w_is_gpr;
  logic w_code_ok;
  logic w_legal;
  logic w_illegal;

  always_comb begin
    w_is_gpr  = (dest_sel < C_SEL_GPR_END);
    w_code_ok = w_is_gpr ||
                (dest_sel == C_SEL_HI)  || (dest_sel == C_SEL_LO)  ||
                (dest_sel == C_SEL_PC)  || (dest_sel == C_SEL_MDR) ||
                (dest_sel == C_SEL_OUT) || (dest_sel == C_SEL_MAR);
    w_legal   = dest_wr &&  w_code_ok;
    w_illegal = dest_wr && !w_code_ok;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= 32'h0;
      r_hi  <= 32'h0;
      r_lo  <= 32'h0;
      r_zhi <= 32'h0;
      r_zlo <= 32'h0;
      r_pc  <= 32'h0;
      r_mdr <= 32'h0;
      r_out <= 32'h0;
      r_mar <= 32'h0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_legal && w_is_gpr && (dest_sel[3:0] == 4'(i))) r_gpr[i] <= bus_data;
      end
      if (w_legal && dest_sel == C_SEL_HI)  r_hi  <= bus_data;
      if (w_legal && dest_sel == C_SEL_LO)  r_lo  <= bus_data;
      if (w_legal && dest_sel == C_SEL_OUT) r_out <= bus_data;
      if (w_legal && dest_sel == C_SEL_MAR) r_mar <= bus_data;
      if (w_legal && dest_sel == C_SEL_MDR) r_mdr <= md_read ? mem_data_in : bus_data;
      if (z_in) begin
        r_zhi <= alu_result[63:32];
        r_zlo <= alu_result[31:0];
      end
      // An explicit bus load of PC wins over a coincident increment.
      if (w_legal && dest_sel == C_SEL_PC) r_pc <= bus_data;
      else if (pc_inc)                     r_pc <= r_pc + 32'd1;
      r_ack <= w_legal;
      // A new illegal write outranks clr_err so no error is lost.
      if (w_illegal)    r_err <= 1'b1;
      else if (clr_err) r_err <= 1'b0;
    end
  end

  assign BusMuxInR0    = r_gpr[0];
  assign BusMuxInR1    = r_gpr[1];
  assign BusMuxInR2    = r_gpr[2];
  assign BusMuxInR3    = r_gpr[3];
  assign BusMuxInR4    = r_gpr[4];
  assign BusMuxInR5    = r_gpr[5];
  assign BusMuxInR6    = r_gpr[6];
  assign BusMuxInR7    = r_gpr[7];
  assign BusMuxInR8    = r_gpr[8];
  assign BusMuxInR9    = r_gpr[9];
  assign BusMuxInR10   = r_gpr[10];
  assign BusMuxInR11   = r_gpr[11];
  assign BusMuxInR12   = r_gpr[12];
  assign BusMuxInR13   = r_gpr[13];
  assign BusMuxInR14   = r_gpr[14];
  assign BusMuxInR15   = r_gpr[15];
  assign Hi_Data_Out   = r_hi;
  assign Lo_Data_Out   = r_lo;
  assign ZHi_Data_Out  = r_zhi;
  assign ZLo_Data_Out  = r_zlo;
  assign PC_Data_Out   = r_pc;
  assign MDR_Data_Out  = r_mdr;
  assign Out_Port_Data = r_out;
  assign MAR_Data_Out  = r_mar;
  assign wr_ack        = r_ack;
  assign wr_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_dest_regs.sv
// ============================================================================
// Module      : tb_bus_dest_regs
// Description : Directed plus random checks of bus_dest_regs against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_dest_regs;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [31:0] bus_data;
  logic [4:0]  dest_sel;
  logic        dest_wr;
  logic        md_read;
  logic [31:0] mem_data_in;
  logic        z_in;
  logic [63:0] alu_result;
  logic        pc_inc;
  logic        clr_err;
  wire  [31:0] dut_out [0:23];
  wire         wr_ack;
  wire         wr_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model slots: 0-15 GPR, 16 HI, 17 LO, 18 ZHi, 19 ZLo, 20 PC, 21 MDR, 22 OUT, 23 MAR
  logic [31:0] m_reg [0:23];
  logic        m_ack;
  logic        m_err;

  always #5 clock = ~clock;

  bus_dest_regs #(.DEST_W(5)) dut (
    .clock(clock), .clear_n(clear_n), .bus_data(bus_data), .dest_sel(dest_sel),
    .dest_wr(dest_wr), .md_read(md_read), .mem_data_in(mem_data_in),
    .z_in(z_in), .alu_result(alu_result), .pc_inc(pc_inc), .clr_err(clr_err),
    .BusMuxInR0(dut_out[0]),   .BusMuxInR1(dut_out[1]),   .BusMuxInR2(dut_out[2]),
    .BusMuxInR3(dut_out[3]),   .BusMuxInR4(dut_out[4]),   .BusMuxInR5(dut_out[5]),
    .BusMuxInR6(dut_out[6]),   .BusMuxInR7(dut_out[7]),   .BusMuxInR8(dut_out[8]),
    .BusMuxInR9(dut_out[9]),   .BusMuxInR10(dut_out[10]), .BusMuxInR11(dut_out[11]),
    .BusMuxInR12(dut_out[12]), .BusMuxInR13(dut_out[13]), .BusMuxInR14(dut_out[14]),
    .BusMuxInR15(dut_out[15]),
    .Hi_Data_Out(dut_out[16]),  .Lo_Data_Out(dut_out[17]),
    .ZHi_Data_Out(dut_out[18]), .ZLo_Data_Out(dut_out[19]),
    .PC_Data_Out(dut_out[20]),  .MDR_Data_Out(dut_out[21]),
    .Out_Port_Data(dut_out[22]), .MAR_Data_Out(dut_out[23]),
    .wr_ack(wr_ack), .wr_err(wr_err)
  );

  function automatic bit code_legal(input int code);
    return (code < 18) || (code >= 20 && code <= 23);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    for (int i = 0; i < 24; i++) check($sformatf("slot%0d", i), dut_out[i], m_reg[i]);
    check("wr_ack", {31'b0, wr_ack}, {31'b0, m_ack});
    check("wr_err", {31'b0, wr_err}, {31'b0, m_err});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 24; i++) m_reg[i] = 32'h0;
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  // Apply the spec rules for one rising edge using the currently driven inputs.
  task automatic model_edge();
    bit legal, illegal;
    legal   = dest_wr &&  code_legal(int'(dest_sel));
    illegal = dest_wr && !code_legal(int'(dest_sel));
    if (z_in) begin
      m_reg[18] = alu_result[63:32];
      m_reg[19] = alu_result[31:0];
    end
    if (pc_inc) m_reg[20] = m_reg[20] + 32'd1;
    if (legal) m_reg[dest_sel] = (dest_sel == 5'd21 && md_read) ? mem_data_in : bus_data;
    m_ack = legal;
    if (illegal) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
  endtask

  task automatic idle();
    bus_data = 32'h0; dest_sel = 5'd0; dest_wr = 1'b0; md_read = 1'b0;
    mem_data_in = 32'h0; z_in = 1'b0; alu_result = 64'h0; pc_inc = 1'b0; clr_err = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
    idle();
  endtask

  task automatic bus_write(input int sel, input logic [31:0] data);
    dest_sel = 5'(sel); bus_data = data; dest_wr = 1'b1;
    cycle();
  endtask

  initial begin
    idle();
    clear_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    clear_n = 1'b1;

    // Reset pulse mid-cycle clears everything immediately
    bus_write(5, 32'h12345678);
    check("r5_loaded", dut_out[5], 32'h12345678);
    #2 clear_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("r5_async_clr", dut_out[5], 32'h0);
    @(posedge clock); #1;
    clear_n = 1'b1;

    // Plain register write with one-cycle ack
    bus_write(7, 32'hDEADBEEF);
    check("r7_write", dut_out[7], 32'hDEADBEEF);
    check("ack_pulse", {31'b0, wr_ack}, 32'h1);
    cycle();
    check("ack_drop", {31'b0, wr_ack}, 32'h0);

    // Back-to-back writes, R0 is ordinary
    bus_write(0, 32'hCAFEF00D);
    check("ack_b2b_1", {31'b0, wr_ack}, 32'h1);
    bus_write(15, 32'h0BADC0DE);
    check("ack_b2b_2", {31'b0, wr_ack}, 32'h1);
    check("r0_write", dut_out[0], 32'hCAFEF00D);

    // MDR source select
    md_read = 1'b1; mem_data_in = 32'hA5A5A5A5;
    bus_write(21, 32'h1);
    check("mdr_mem", dut_out[21], 32'hA5A5A5A5);
    md_read = 1'b0; mem_data_in = 32'hA5A5A5A5;
    bus_write(21, 32'h1);
    check("mdr_bus", dut_out[21], 32'h1);

    // PC wrap and bus-write priority over increment
    bus_write(20, 32'hFFFFFFFF);
    pc_inc = 1'b1;
    cycle();
    check("pc_wrap", dut_out[20], 32'h0);
    pc_inc = 1'b1;
    bus_write(20, 32'h40);
    check("pc_prio", dut_out[20], 32'h40);

    // Illegal code sets a sticky error, clr_err clears it
    z_in = 1'b1; alu_result = 64'h00000077_00000088;
    cycle();
    bus_write(18, 32'h55555555);
    check("zhi_kept", dut_out[18], 32'h77);
    check("err_set", {31'b0, wr_err}, 32'h1);
    check("ack_none", {31'b0, wr_ack}, 32'h0);
    cycle();
    check("err_held", {31'b0, wr_err}, 32'h1);
    clr_err = 1'b1;
    bus_write(27, 32'h1);
    check("err_clr_vs_set", {31'b0, wr_err}, 32'h1);
    clr_err = 1'b1;
    cycle();
    check("err_clr", {31'b0, wr_err}, 32'h0);

    // ZHi/ZLo load coincident with bus write to HI
    z_in = 1'b1; alu_result = 64'h00000001_00000002;
    bus_write(16, 32'h9);
    check("zhi_sim", dut_out[18], 32'h1);
    check("zlo_sim", dut_out[19], 32'h2);
    check("hi_sim",  dut_out[16], 32'h9);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus_data    = $urandom;
      dest_sel    = 5'($urandom_range(0, 31));
      dest_wr     = ($urandom_range(0, 2) != 0);
      md_read     = 1'($urandom);
      mem_data_in = $urandom;
      z_in        = ($urandom_range(0, 3) == 0);
      alu_result  = {$urandom, $urandom};
      pc_inc      = ($urandom_range(0, 2) == 0);
      clr_err     = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_dest_regs.md
BUS_DEST_REGS -- requirements
Module: bus_dest_regs

Interface
REQ-001 SHALL have parameter DEST_W, default 5, meaning the width of the destination-select code.
REQ-002 SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 SHALL have port clear_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port bus_data, input, 32, the value currently driven on the shared bus.
REQ-005 SHALL have port dest_sel, input, DEST_W, the destination code: 0-15 = R0-R15, 16 = HI, 17 = LO, 20 = PC, 21 = MDR, 22 = OUTPORT, 23 = MAR.
REQ-006 SHALL have port dest_wr, input, 1, the bus-write strobe, qualified by dest_sel.
REQ-007 SHALL have port md_read, input, 1, the MDR source select: 1 = mem_data_in, 0 = bus_data.
REQ-008 SHALL have port mem_data_in, input, 32, the memory read data.
REQ-009 SHALL have port z_in, input, 1, the strobe that captures alu_result into ZHi/ZLo.
REQ-010 SHALL have port alu_result, input, 64, the ALU output: [63:32] goes to ZHi, [31:0] goes to ZLo.
REQ-011 SHALL have port pc_inc, input, 1, the PC increment strobe.
REQ-012 SHALL have port clr_err, input, 1, which clears the sticky error flag.
REQ-013 SHALL have ports BusMuxInR0..BusMuxInR15, output, 32 each, holding the register contents that feed the bus mux.
REQ-014 SHALL have ports Hi_Data_Out, Lo_Data_Out, ZHi_Data_Out, ZLo_Data_Out, PC_Data_Out and MDR_Data_Out, output, 32 each, feeding the bus mux.
REQ-015 SHALL have ports Out_Port_Data and MAR_Data_Out, output, 32 each, feeding the external port and the memory address.
REQ-016 SHALL have port wr_ack, output, 1, a one-cycle pulse confirming an accepted write.
REQ-017 SHALL have port wr_err, output, 1, a sticky flag set by an illegal write code.

Function
REQ-018 SHALL update all storage only on the rising edge of clock; there are no combinational paths from inputs to storage outputs.
REQ-019 SHALL capture bus_data into the register selected by dest_sel when dest_wr=1; the new value is visible on the output one cycle later (latency 1).
REQ-020 SHALL load MDR from mem_data_in when dest_wr=1, dest_sel=21 and md_read=1, and from bus_data otherwise.
REQ-021 SHALL treat dest_sel codes 18, 19 and 24-31 as illegal when dest_wr=1: no register changes, wr_err is set and wr_ack stays 0.
REQ-022 SHALL ignore dest_sel entirely when dest_wr=0.
REQ-023 SHALL assert wr_ack for exactly one cycle, in the cycle after each legal write; back-to-back legal writes SHALL give back-to-back wr_ack pulses.
REQ-024 SHALL load ZHi/ZLo from alu_result whenever z_in=1, independent of dest_wr, so both can occur in the same cycle.
REQ-025 SHALL set PC to PC+1 on pc_inc=1, with modulo 2^32 wrap (0xFFFFFFFF -> 0x00000000).
REQ-026 SHALL give a bus write to PC (dest_wr=1, dest_sel=20) priority when it coincides with pc_inc; the increment is dropped.
REQ-027 SHALL hold wr_err until clr_err=1 or reset; when clr_err and a new illegal write coincide, the flag SHALL stay at 1.
REQ-028 SHALL treat R0 as an ordinary writable register; no hardwired zero.

Reset
REQ-029 SHALL, while clear_n=0 and asynchronously, force all 24 storage registers to 0x00000000, wr_ack to 0 and wr_err to 0.
REQ-030 SHALL complete no write in a cycle that is interrupted by reset; after the synchronous release of clear_n, the first edge with dest_wr=1 SHALL write normally.

Verification
REQ-031 SHALL cover reset: pulse clear_n low mid-cycle after loading R5=0x12345678 -> all outputs read 0 immediately, and wr_ack and wr_err read 0.
REQ-032 SHALL cover register writes: dest_sel=7, bus_data=0xDEADBEEF, dest_wr=1 for one cycle -> next cycle BusMuxInR7=0xDEADBEEF, wr_ack=1 for one cycle, all other registers unchanged.
REQ-033 SHALL cover the MDR source: dest_sel=21, md_read=1, mem_data_in=0xA5A5A5A5, bus_data=0x1 -> MDR_Data_Out=0xA5A5A5A5; repeating with md_read=0 -> MDR_Data_Out=0x1.
REQ-034 SHALL cover PC behaviour: PC=0xFFFFFFFF then pc_inc -> PC=0; pc_inc together with a bus write of 0x40 to PC -> PC=0x40.
REQ-035 SHALL cover illegal codes: dest_sel=18, dest_wr=1 -> ZHi unchanged, wr_err=1 and held; clr_err=1 -> wr_err=0 next cycle.
REQ-036 SHALL cover simultaneous writes: z_in=1 with alu_result=0x00000001_00000002 and a bus write to HI=0x9 in the same cycle -> ZHi=1, ZLo=2, HI=9.
